// File: rtl/iob_master.sv
// iob_master: runs one 68000-style cycle on the slow IOB bus for each FSB select and generates the 6800 E clock
module iob_master #(
    parameter int TICK_DIV = 4,
    parameter int E_LOW    = 6,
    parameter int E_HIGH   = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic CLK,
    input  logic nRES,
    input  logic IOCS,
    input  logic IACS,
    input  logic nFAS,
    input  logic nFWE,
    input  logic nFLDS,
    input  logic nFUDS,
    input  logic nDTACK,
    input  logic nVPA,
    input  logic nBERR,
    output logic nAS,
    output logic nLDS,
    output logic nUDS,
    output logic nWEo,
    output logic nVMA,
    output logic E,
    output logic ALE,
    output logic DLE,
    output logic IOReady,
    output logic IOErr
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int EW = $clog2(E_LOW + E_HIGH);
    localparam int OW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, S0, S2, WAIT, VPAWAIT, S6, S7, ERR} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [EW-1:0] ecnt_q, ecnt_d;
    logic          e_q, e_d;
    logic [5:0]    sync_q, sync_d;
    logic [OW-1:0] to_q, to_d;
    logic [1:0]    vph_q, vph_d;
    logic          nas_q, nas_d, nlds_q, nlds_d, nuds_q, nuds_d, nwe_q, nwe_d, nvma_q, nvma_d;
    logic          ale_q, ale_d, dle_q, dle_d, rdy_q, rdy_d, err_q, err_d;
    logic          done_q, done_d, abort_q, abort_d;
    logic          wr_q, wr_d, lds_q, lds_d, uds_q, uds_d;
    logic          tick, dtack_s, vpa_s, berr_s;

    assign tick = tick_q == TW'(TICK_DIV - 1);
    assign {berr_s, vpa_s, dtack_s} = sync_q[5:3];
    assign nAS     = nas_q;
    assign nLDS    = nlds_q;
    assign nUDS    = nuds_q;
    assign nWEo    = nwe_q;
    assign nVMA    = nvma_q;
    assign E       = e_q;
    assign ALE     = ale_q;
    assign DLE     = dle_q;
    assign IOReady = rdy_q;
    assign IOErr   = err_q;

    // free-running tick divider, E clock counter and two-stage input synchronisers
    always_comb begin
        tick_d = tick ? '0 : tick_q + 1'b1;
        ecnt_d = !tick ? ecnt_q : (ecnt_q == EW'(E_LOW + E_HIGH - 1)) ? '0 : ecnt_q + 1'b1;
        e_d    = ecnt_d >= EW'(E_LOW);
        sync_d = {sync_q[2:0], nBERR, nVPA, nDTACK};
    end

    // bus-cycle sequencer: next state, strobes and one-CLK status pulses
    always_comb begin
        state_d = state_q;
        to_d    = to_q;
        vph_d   = vph_q;
        nas_d   = nas_q;
        nlds_d  = nlds_q;
        nuds_d  = nuds_q;
        nwe_d   = nwe_q;
        nvma_d  = nvma_q;
        wr_d    = wr_q;
        lds_d   = lds_q;
        uds_d   = uds_q;
        done_d  = done_q;
        ale_d   = 1'b0;
        dle_d   = 1'b0;
        rdy_d   = 1'b0;
        err_d   = 1'b0;
        abort_d = (state_q != IDLE) && (abort_q || nFAS);
        case (state_q)
            IDLE: begin
                to_d  = '0;
                vph_d = '0;
                if (!nFAS && (IOCS || IACS) && !done_q) begin
                    ale_d   = 1'b1;
                    wr_d    = nFWE;
                    lds_d   = nFLDS;
                    uds_d   = nFUDS;
                    state_d = S0;
                end
            end
            S0: if (tick) begin
                nas_d   = 1'b0;
                nwe_d   = wr_q;
                nlds_d  = wr_q ? lds_q : 1'b1;
                nuds_d  = wr_q ? uds_q : 1'b1;
                state_d = S2;
            end
            S2: if (tick) begin
                nlds_d  = lds_q;
                nuds_d  = uds_q;
                state_d = WAIT;
            end
            WAIT: if (tick) begin
                to_d = to_q + 1'b1;
                if (!berr_s) state_d = ERR;
                else if (!dtack_s) begin
                    dle_d   = 1'b1;
                    state_d = S6;
                end
                else if (!vpa_s) state_d = VPAWAIT;
                else if (to_q == OW'(TIMEOUT - 1)) state_d = ERR;
            end
            VPAWAIT: begin
                if (!berr_s) state_d = ERR;
                else if (vph_q == 2'd0) begin
                    if (!e_q) begin
                        nvma_d = 1'b0;
                        vph_d  = 2'd1;
                    end
                end
                else if (vph_q == 2'd1) begin
                    if (e_q) vph_d = 2'd2;
                end
                else if (!e_q) begin
                    dle_d   = 1'b1;
                    state_d = S6;
                end
            end
            S6: if (tick) state_d = S7;
            S7, ERR: begin
                {nas_d, nlds_d, nuds_d, nwe_d, nvma_d} = 5'h1F;
                rdy_d   = (state_q == S7) && !abort_d;
                err_d   = (state_q == ERR) && !abort_d;
                done_d  = !abort_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (nFAS) done_d = 1'b0;
    end

    // state register; reset releases every strobe immediately
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state_q <= IDLE;
            tick_q  <= '0;
            ecnt_q  <= '0;
            e_q     <= 1'b0;
            sync_q  <= '1;
            to_q    <= '0;
            vph_q   <= '0;
            nas_q   <= 1'b1;
            nlds_q  <= 1'b1;
            nuds_q  <= 1'b1;
            nwe_q   <= 1'b1;
            nvma_q  <= 1'b1;
            ale_q   <= 1'b0;
            dle_q   <= 1'b0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            wr_q    <= 1'b1;
            lds_q   <= 1'b1;
            uds_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            ecnt_q  <= ecnt_d;
            e_q     <= e_d;
            sync_q  <= sync_d;
            to_q    <= to_d;
            vph_q   <= vph_d;
            nas_q   <= nas_d;
            nlds_q  <= nlds_d;
            nuds_q  <= nuds_d;
            nwe_q   <= nwe_d;
            nvma_q  <= nvma_d;
            ale_q   <= ale_d;
            dle_q   <= dle_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            wr_q    <= wr_d;
            lds_q   <= lds_d;
            uds_q   <= uds_d;
        end
    end
endmodule

// File: tb/tb_iob_master.sv
// tb_iob_master: directed checks of IOB cycles, E clock, timeout, BERR, abort and reset
module tb_iob_master;
    localparam int TD = 4;
    localparam int W_NAS = 0, W_LDS = 1, W_UDS = 2, W_NWE = 3, W_VMA = 4, W_E = 5, W_DLE = 6, W_RDY = 7, W_ERR = 8;

    logic CLK = 1'b0;
    logic nRES, IOCS, IACS, nFAS, nFWE, nFLDS, nFUDS, nDTACK, nVPA, nBERR;
    logic nAS, nLDS, nUDS, nWEo, nVMA, E, ALE, DLE, IOReady, IOErr;
    int tests = 0, fails = 0, ready_cnt = 0, err_cnt = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_e;

    iob_master dut (
        .CLK(CLK), .nRES(nRES), .IOCS(IOCS), .IACS(IACS), .nFAS(nFAS), .nFWE(nFWE),
        .nFLDS(nFLDS), .nFUDS(nFUDS), .nDTACK(nDTACK), .nVPA(nVPA), .nBERR(nBERR),
        .nAS(nAS), .nLDS(nLDS), .nUDS(nUDS), .nWEo(nWEo), .nVMA(nVMA), .E(E),
        .ALE(ALE), .DLE(DLE), .IOReady(IOReady), .IOErr(IOErr)
    );

    always #5 CLK = ~CLK;

    function automatic logic sig(input int w);
        case (w)
            W_NAS: return nAS;
            W_LDS: return nLDS;
            W_UDS: return nUDS;
            W_NWE: return nWEo;
            W_VMA: return nVMA;
            W_E:   return E;
            W_DLE: return DLE;
            W_RDY: return IOReady;
            default: return IOErr;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_sig(input string tag, input int w, input logic v, input int max, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (sig(w) !== v && n < max);
        chk(tag, 32'(sig(w)), 32'(v));
    endtask

    task automatic launch(input logic cs, input logic ia, input logic fwe, input logic flds, input logic fuds);
        IOCS = cs; IACS = ia; nFWE = fwe; nFLDS = flds; nFUDS = fuds; nFAS = 1'b0;
    endtask

    task automatic bus_idle();
        nFAS = 1'b1; IOCS = 1'b0; IACS = 1'b0; nFWE = 1'b1; nFLDS = 1'b1; nFUDS = 1'b1;
        nDTACK = 1'b1; nVPA = 1'b1; nBERR = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        if (nRES === 1'b1 && (IOReady === 1'b1 || IOErr === 1'b1)) begin
            ready_cnt += int'(IOReady);
            err_cnt += int'(IOErr);
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_status: observed %b expected none", {IOReady, IOErr});
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                assert ({IOReady, IOErr} === mon_e) else begin
                    fails++;
                    $error("FAIL status_kind: observed %b expected %b", {IOReady, IOErr}, mon_e);
                end
            end
        end
    end

    initial begin
        int n, lows;
        nRES = 1'b0;
        nFAS = 1'b1; IOCS = 1'b0; IACS = 1'b0; nFWE = 1'b1; nFLDS = 1'b1; nFUDS = 1'b1;
        nDTACK = 1'b1; nVPA = 1'b1; nBERR = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset_outs", 32'({nAS, nLDS, nUDS, nWEo, nVMA, E, ALE, DLE, IOReady, IOErr}), 32'b11111_00000);
        nRES = 1'b1;
        wait_sig("e_start_low", W_E, 1'b0, 100, n);
        wait_sig("e_rise", W_E, 1'b1, 100, n);
        wait_sig("e_fall", W_E, 1'b0, 100, n);
        chk("e_high_len", n, 4 * TD);
        wait_sig("e_rise2", W_E, 1'b1, 100, n);
        chk("e_low_len", n, 6 * TD);
        chk("idle_no_status", ready_cnt + err_cnt, 0);

        nDTACK = 1'b0;
        repeat (3) @(negedge CLK);
        exp_q.push_back(2'b10);
        launch(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        chk("rd_ale", ALE, 1);
        wait_sig("rd_nas", W_NAS, 1'b0, 20, n);
        chk("rd_nlds_with_nas", nLDS, 0);
        chk("rd_nuds_idle", nUDS, 1);
        chk("rd_nwe", nWEo, 1);
        wait_sig("rd_dle", W_DLE, 1'b1, 40, n);
        wait_sig("rd_dle_off", W_DLE, 1'b0, 10, n);
        chk("rd_dle_len", n, 1);
        wait_sig("rd_ready", W_RDY, 1'b1, 20, n);
        chk("rd_strobes_end", 32'({nAS, nLDS, nUDS, nVMA}), 32'hF);
        lows = 0;
        repeat (60) begin
            @(negedge CLK);
            lows += int'(nAS === 1'b0);
        end
        chk("rd_no_relaunch", lows, 0);
        chk("rd_ready_once", ready_cnt, 1);
        bus_idle();

        exp_q.push_back(2'b10);
        launch(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_sig("wr_nas", W_NAS, 1'b0, 20, n);
        chk("wr_nwe_at_nas", nWEo, 0);
        chk("wr_ds_late", 32'({nLDS, nUDS}), 32'b11);
        wait_sig("wr_nlds", W_LDS, 1'b0, 20, n);
        chk("wr_ds_delay", n, TD);
        chk("wr_nuds", nUDS, 0);
        repeat (4 * TD) @(negedge CLK);
        chk("wr_nwe_hold", nWEo, 0);
        nDTACK = 1'b0;
        wait_sig("wr_ready", W_RDY, 1'b1, 40, n);
        chk("wr_ready_lat", n, 2 * TD + 1);
        chk("wr_nwe_end", nWEo, 1);
        bus_idle();
        chk("wr_ready_once", ready_cnt, 2);

        nVPA = 1'b0;
        wait_sig("vpa_pre_low", W_E, 1'b0, 100, n);
        wait_sig("vpa_pre_rise", W_E, 1'b1, 100, n);
        repeat (TD) @(negedge CLK);
        exp_q.push_back(2'b10);
        launch(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_sig("vpa_nvma", W_VMA, 1'b0, 100, n);
        chk("vpa_vma_in_e_low", E, 0);
        wait_sig("vpa_e_rise", W_E, 1'b1, 100, n);
        chk("vpa_vma_held", nVMA, 0);
        wait_sig("vpa_e_fall", W_E, 1'b0, 100, n);
        wait_sig("vpa_ready", W_RDY, 1'b1, 4 * TD, n);
        chk("vpa_ready_lat", n, TD + 1);
        chk("vpa_vma_end", nVMA, 1);
        bus_idle();
        chk("vpa_ready_once", ready_cnt, 3);

        nDTACK = 1'b0; nVPA = 1'b0;
        repeat (3) @(negedge CLK);
        exp_q.push_back(2'b10);
        launch(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_sig("dv_nas", W_NAS, 1'b0, 20, n);
        lows = 0;
        for (int i = 0; i < 40 && nAS !== 1'b1; i++) begin
            @(negedge CLK);
            lows += int'(nVMA === 1'b0);
        end
        chk("dv_nas_end", nAS, 1);
        chk("dv_dtack_wins", lows, 0);
        bus_idle();
        chk("dv_ready", ready_cnt, 4);

        nDTACK = 1'b0; nBERR = 1'b0;
        repeat (3) @(negedge CLK);
        exp_q.push_back(2'b01);
        launch(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_sig("bd_nas", W_NAS, 1'b0, 20, n);
        wait_sig("bd_err", W_ERR, 1'b1, 40, n);
        chk("bd_strobes", 32'({nAS, nLDS, nUDS, nWEo, nVMA}), 32'h1F);
        bus_idle();
        chk("bd_counts", 32'({ready_cnt[7:0], err_cnt[7:0]}), 32'h0401);

        launch(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_sig("ab_nas", W_NAS, 1'b0, 20, n);
        nFAS = 1'b1;
        repeat (2 * TD) @(negedge CLK);
        nDTACK = 1'b0;
        wait_sig("ab_nas_end", W_NAS, 1'b1, 60, n);
        bus_idle();
        chk("ab_suppressed", 32'({ready_cnt[7:0], err_cnt[7:0]}), 32'h0401);

        exp_q.push_back(2'b01);
        launch(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_sig("to_nas", W_NAS, 1'b0, 20, n);
        wait_sig("to_err", W_ERR, 1'b1, 1100, n);
        chk("to_window", 32'(n >= 256 * TD && n <= 258 * TD), 1);
        chk("to_strobes", 32'({nAS, nLDS, nUDS, nWEo, nVMA}), 32'h1F);
        bus_idle();
        chk("to_counts", 32'({ready_cnt[7:0], err_cnt[7:0]}), 32'h0402);

        exp_q.push_back(2'b01);
        launch(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_sig("be_nas", W_NAS, 1'b0, 20, n);
        repeat (3 * TD) @(negedge CLK);
        nBERR = 1'b0;
        wait_sig("be_err", W_ERR, 1'b1, 40, n);
        chk("be_strobes", 32'({nAS, nLDS, nUDS, nWEo, nVMA}), 32'h1F);
        bus_idle();
        chk("be_counts", 32'({ready_cnt[7:0], err_cnt[7:0]}), 32'h0403);

        launch(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_sig("rs_nas", W_NAS, 1'b0, 20, n);
        repeat (3 * TD) @(negedge CLK);
        #2 nRES = 1'b0;
        #1 chk("rs_async_strobes", 32'({nAS, nLDS, nUDS, nWEo, nVMA, E}), 32'b111110);
        bus_idle();
        nRES = 1'b1;
        nDTACK = 1'b0;
        repeat (3) @(negedge CLK);
        exp_q.push_back(2'b10);
        launch(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_sig("rs_fresh_nas", W_NAS, 1'b0, 20, n);
        wait_sig("rs_fresh_ready", W_RDY, 1'b1, 40, n);
        bus_idle();
        chk("rs_counts", 32'({ready_cnt[7:0], err_cnt[7:0]}), 32'h0503);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/iob_master.md
Name: iob_master

Overview:
- Responder for the chip-select decoder's IOB-domain selects (IOCS, IACS).
- When the fast-side (FSB) cycle targets an IOB device, it runs one 68000-style cycle on the slow I/O bus toward SCSI, SCC, IWM, VIA, IACK or video-RAM writes.
- Cycle termination is by DTACK, VPA (E-synchronous) or BERR. A one-cycle ready/error indication is returned to the FSB controller.
- It also generates the 6800 E clock used by the VIA.

Parameters:
- TICK_DIV, 4: CLK cycles per IOB state tick; an IOB half-clock equals TICK_DIV CLK.
- E_LOW, 6: IOB ticks E is low per period.
- E_HIGH, 4: IOB ticks E is high per period.
- TIMEOUT, 255: IOB ticks waited for termination before forcing a bus error.

Ports:
- CLK  in  1  system clock
- nRES  in  1  asynchronous active-low reset
- IOCS  in  1  IOB-domain select from decoder
- IACS  in  1  interrupt-acknowledge select; a cycle with IACS uses the same path
- nFAS  in  1  FSB address strobe, active low
- nFWE  in  1  FSB write strobe, active low (1 = read)
- nFLDS  in  1  FSB lower data strobe
- nFUDS  in  1  FSB upper data strobe
- nDTACK  in  1  IOB data acknowledge, asynchronous
- nVPA  in  1  IOB valid peripheral address, asynchronous
- nBERR  in  1  IOB bus error, asynchronous
- nAS  out  1  IOB address strobe
- nLDS  out  1  IOB lower data strobe
- nUDS  out  1  IOB upper data strobe
- nWEo  out  1  IOB write
- nVMA  out  1  IOB valid memory address
- E  out  1  6800 E clock
- ALE  out  1  address/data-out latch enable, FSB to IOB
- DLE  out  1  read-data latch enable, IOB to FSB
- IOReady  out  1  one-CLK pulse: cycle complete
- IOErr  out  1  one-CLK pulse: cycle ended with BERR or timeout

Behaviour:
- Clocking and reset:
  - One clock domain, CLK. Reset is asynchronous and active-low on nRES.
  - On reset: nAS=nLDS=nUDS=nWEo=nVMA=1; E=0; ALE=DLE=IOReady=IOErr=0; FSM=IDLE; tick, E and timeout counters=0.
  - Reset mid-cycle deasserts every strobe in the same edge and abandons the cycle; no IOReady is issued.
- Tick and E generation:
  - A free-running tick counter 0..TICK_DIV-1 produces tick=1 on terminal count.
  - The E counter advances on tick. E is low for E_LOW ticks, then high for E_HIGH ticks, and wraps.
  - E runs continuously from reset.
- Synchronisers: nDTACK, nVPA and nBERR each pass through a two-flop synchroniser. Only the synchronised versions are used.
- FSM transitions (advance on tick unless noted):
  - IDLE:
    - Start condition (evaluated every CLK): nFAS=0 and (IOCS or IACS) and the "done" flag is clear.
    - On start: ALE=1 for 1 CLK; capture nFWE, nFLDS, nFUDS; go to S0.
  - S0: on tick, nAS=0; nWEo=captured write. For a write, nLDS/nUDS are not driven yet. For a read, they are asserted together with nAS. Go to S2.
  - S2:
    - Write: assert the captured data strobes. Go to WAIT.
    - Read: go straight to WAIT.
  - WAIT: timeout counter increments per tick. Priority on each tick:
    1. BERR sync low -> ERR.
    2. DTACK sync low -> S6.
    3. VPA sync low -> VPAWAIT.
    4. Timeout counter = TIMEOUT -> ERR.
  - VPAWAIT:
    - Wait for E low, then assert nVMA=0.
    - Wait for an E rising edge, then wait for the E falling edge; go to S6.
    - BERR during VPAWAIT -> ERR.
  - S6: DLE=1 for 1 CLK (read data latched). Next tick go to S7.
  - S7: deassert nAS, nLDS, nUDS and nVMA together; nWEo=1. Pulse IOReady for 1 CLK; set "done"; go to IDLE.
  - ERR: deassert all strobes; pulse IOErr for 1 CLK (IOReady stays 0); set "done"; go to IDLE.
- "done" flag: cleared when nFAS=1. This prevents re-launching the same FSB cycle.
- Boundary cases:
  - nFAS rising mid-cycle (FSB abort): the IOB cycle still completes to S7/ERR to keep IOB protocol legal, but IOReady/IOErr are suppressed.
  - DTACK and VPA both low: DTACK wins.
  - BERR with DTACK in the same sample: BERR wins.
  - Timeout counter is reset in IDLE.
  - Minimum IOB cycle is 4 ticks: S0, S2, WAIT with DTACK already low, then S6/S7.

Test Plan:
1. Reset held, then released -> all strobes high, E toggles with period 10 ticks (low 6 / high 4); no IOReady.
2. Read, IOCS=1, nFAS=0, nFWE=1, nFLDS=0, nFUDS=1, nDTACK tied low -> nAS and nLDS fall on the same tick; nUDS stays high; DLE pulses; IOReady pulses exactly once; strobes high after S7; no relaunch until nFAS=1.
3. Write, IACS=1, nFWE=0, both DS low, DTACK asserted 5 ticks after nAS -> data strobes assert one tick after nAS; nWEo=0 throughout; IOReady follows the DTACK sample by 2 synchroniser CLK plus the S6/S7 ticks; nWEo=1 at S7.
4. VPA cycle (nVPA low, nDTACK high), started mid-E-high -> nVMA falls only while E low; termination on the following E falling edge; IOReady once; nVMA high at end.
5. No response -> IOErr pulses after 255 ticks in WAIT; IOReady=0. A separate run with nBERR low 3 ticks in -> IOErr and strobes released.
6. nRES pulsed low while in WAIT -> strobes high asynchronously. After release, a fresh nFAS cycle completes normally.
